// File: rtl/cpu_pkg.sv
// Shared types for the hazard controller: FSM states, forwarding-select codes and scoreboard entry.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_STALL   = 2'd1,
    ST_HALTING = 2'd2,
    ST_HALTED  = 2'd3
  } hz_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  // Entries store register indices at a fixed width so RW may range up to 8.
  localparam int SB_RW_MAX = 8;

  typedef struct packed {
    logic                 valid;
    logic                 load;
    logic [SB_RW_MAX-1:0] rg;
  } sb_entry_t;

  function automatic logic sb_hit(input sb_entry_t e, input logic [SB_RW_MAX-1:0] idx);
    return e.valid && (e.rg == idx);
  endfunction

  // hit[0] = EX, hit[1] = MEM, hit[2] = WB; the youngest producer wins.
  function automatic logic [1:0] fwd_pick(input logic [2:0] hit);
    if (hit[0]) return FWD_EX;
    if (hit[1]) return FWD_MEM;
    if (hit[2]) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode/execute control bundle between the pipeline (master) and hazard_ctrl (slave).
interface hazard_ctrl_if #(
  parameter int RW   = 3,
  parameter int CNTW = 16
);
  logic          id_valid;
  logic [RW-1:0] id_rs1;
  logic [RW-1:0] id_rs2;
  logic          id_use1;
  logic          id_use2;
  logic          id_wen;
  logic [RW-1:0] id_wreg;
  logic          id_memread;
  logic          id_halt;
  logic          ex_redirect;

  logic            pc_hold;
  logic            ifid_hold;
  logic            ifid_flush;
  logic            idex_bubble;
  logic            halted;
  logic [1:0]      fwd1_sel;
  logic [1:0]      fwd2_sel;
  logic [CNTW-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use1, id_use2, id_wen, id_wreg,
           id_memread, id_halt, ex_redirect,
    input  pc_hold, ifid_hold, ifid_flush, idex_bubble, halted,
           fwd1_sel, fwd2_sel, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use1, id_use2, id_wen, id_wreg,
           id_memread, id_halt, ex_redirect,
    output pc_hold, ifid_hold, ifid_flush, idex_bubble, halted,
           fwd1_sel, fwd2_sel, stall_cnt
  );
endinterface

// File: rtl/hz_scoreboard.sv
// EX/MEM/WB destination scoreboard with source match logic.
// HAZARD_FWD_EN selects load-use-only hazards plus forwarding selects.
module hz_scoreboard
  import cpu_pkg::*;
#(
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue,
  input  logic [RW-1:0] wreg,
  input  logic          wload,
  input  logic [RW-1:0] rs1,
  input  logic [RW-1:0] rs2,
  input  logic          use1,
  input  logic          use2,
  output logic          hazard,
  output logic [1:0]    fwd1_sel,
  output logic [1:0]    fwd2_sel,
  output logic          drain_done
);

  sb_entry_t            sb_ex, sb_mem, sb_wb;
  logic [SB_RW_MAX-1:0] idx1, idx2;
  logic [2:0]           m1, m2;
  logic                 unused_load;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_ex  <= '0;
      sb_mem <= '0;
      sb_wb  <= '0;
    end else begin
      sb_wb  <= sb_mem;
      sb_mem <= sb_ex;
      sb_ex  <= issue ? '{valid: 1'b1, load: wload, rg: SB_RW_MAX'(wreg)} : '0;
    end
  end

  assign idx1 = SB_RW_MAX'(rs1);
  assign idx2 = SB_RW_MAX'(rs2);
  assign m1   = {3{use1}} & {sb_hit(sb_wb, idx1), sb_hit(sb_mem, idx1), sb_hit(sb_ex, idx1)};
  assign m2   = {3{use2}} & {sb_hit(sb_wb, idx2), sb_hit(sb_mem, idx2), sb_hit(sb_ex, idx2)};

  // The WB entry leaves on the coming edge, so the pipe is drained once EX and MEM are empty.
  assign drain_done = !sb_ex.valid && !sb_mem.valid;

`ifdef HAZARD_FWD_EN
  assign hazard      = (m1[0] || m2[0]) && sb_ex.load;
  assign fwd1_sel    = fwd_pick(m1);
  assign fwd2_sel    = fwd_pick(m2);
  assign unused_load = sb_mem.load ^ sb_wb.load;
`else
  assign hazard      = |{m1, m2};
  assign fwd1_sel    = FWD_RF;
  assign fwd2_sel    = FWD_RF;
  assign unused_load = sb_ex.load ^ sb_mem.load ^ sb_wb.load;
`endif

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush/halt FSM and saturating stall counter.
// Build option HAZARD_FWD_EN (in hz_scoreboard) enables forwarding.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int NREG = 8,
  parameter int RW   = 3,
  parameter int CNTW = 16
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave hz
);

  hz_state_e       state, state_nx;
  logic            issue, stall_inc, hazard, drain_done, use1_q, use2_q;
  logic            pc_hold_c, ifid_hold_c, ifid_flush_c, idex_bubble_c, halted_c;
  logic [1:0]      f1, f2;
  logic [CNTW-1:0] cnt;

  assign use1_q = hz.id_use1 && (int'(hz.id_rs1) < NREG);
  assign use2_q = hz.id_use2 && (int'(hz.id_rs2) < NREG);

  hz_scoreboard #(.RW(RW)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .issue      (issue),
    .wreg       (hz.id_wreg),
    .wload      (hz.id_memread),
    .rs1        (hz.id_rs1),
    .rs2        (hz.id_rs2),
    .use1       (use1_q),
    .use2       (use2_q),
    .hazard     (hazard),
    .fwd1_sel   (f1),
    .fwd2_sel   (f2),
    .drain_done (drain_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_RUN;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    pc_hold_c     = 1'b0;
    ifid_hold_c   = 1'b0;
    ifid_flush_c  = 1'b0;
    idex_bubble_c = 1'b0;
    halted_c      = 1'b0;
    issue         = 1'b0;
    stall_inc     = 1'b0;
    if (state == ST_HALTED) begin
      halted_c    = 1'b1;
      pc_hold_c   = 1'b1;
      ifid_hold_c = 1'b1;
    end else if (hz.ex_redirect) begin
      ifid_flush_c  = 1'b1;
      idex_bubble_c = 1'b1;
      state_nx      = ST_RUN;
    end else if (state == ST_HALTING) begin
      pc_hold_c     = 1'b1;
      idex_bubble_c = 1'b1;
      if (drain_done) state_nx = ST_HALTED;
    end else if (hz.id_valid && hazard) begin
      pc_hold_c     = 1'b1;
      ifid_hold_c   = 1'b1;
      idex_bubble_c = 1'b1;
      stall_inc     = 1'b1;
      state_nx      = ST_STALL;
    end else if (hz.id_valid && hz.id_halt) begin
      pc_hold_c     = 1'b1;
      idex_bubble_c = 1'b1;
      state_nx      = ST_HALTING;
    end else begin
      issue    = hz.id_valid && hz.id_wen;
      state_nx = ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         cnt <= '0;
    else if (stall_inc && cnt != '1)  cnt <= cnt + CNTW'(1);
  end

  // Outputs are masked by reset directly so they drop without waiting for a clock.
  assign hz.pc_hold     = rst & pc_hold_c;
  assign hz.ifid_hold   = rst & ifid_hold_c;
  assign hz.ifid_flush  = rst & ifid_flush_c;
  assign hz.idex_bubble = rst & idex_bubble_c;
  assign hz.halted      = rst & halted_c;
  assign hz.fwd1_sel    = rst ? f1 : FWD_RF;
  assign hz.fwd2_sel    = rst ? f2 : FWD_RF;
  assign hz.stall_cnt   = cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized scoreboard bench for hazard_ctrl; two instances differ only in stall counter width.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.RW(3), .CNTW(16)) hif16 ();
  hazard_ctrl_if #(.RW(3), .CNTW(4))  hif4 ();

  hazard_ctrl #(.NREG(8), .RW(3), .CNTW(16)) dut16 (.clk(clk), .rst(rst), .hz(hif16));
  hazard_ctrl #(.NREG(8), .RW(3), .CNTW(4))  dut4  (.clk(clk), .rst(rst), .hz(hif4));

  assign hif4.id_valid    = hif16.id_valid;
  assign hif4.id_rs1      = hif16.id_rs1;
  assign hif4.id_rs2      = hif16.id_rs2;
  assign hif4.id_use1     = hif16.id_use1;
  assign hif4.id_use2     = hif16.id_use2;
  assign hif4.id_wen      = hif16.id_wen;
  assign hif4.id_wreg     = hif16.id_wreg;
  assign hif4.id_memread  = hif16.id_memread;
  assign hif4.id_halt     = hif16.id_halt;
  assign hif4.ex_redirect = hif16.ex_redirect;

  typedef struct {
    bit v; int unsigned rs1, rs2; bit u1, u2, wen; int unsigned wreg; bit ld, halt;
  } instr_t;
  typedef struct { int unsigned rg; bit ld; int unsigned age; } flight_t;
  typedef struct packed {
    logic pc_hold, ifid_hold, ifid_flush, idex_bubble, halted; logic [1:0] f1, f2;
  } outs_t;
  typedef struct { outs_t o; int unsigned stalls; } exp_t;

  exp_t    sbq[$];
  flight_t fl[$];
  instr_t  dirq[$];
  int      checks = 0;
  int      errors = 0;
  bit          m_halting, m_halted, first_ep;
  int unsigned m_stalls, halted_cycles;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic outs_t outs16();
    return {hif16.pc_hold, hif16.ifid_hold, hif16.ifid_flush, hif16.idex_bubble,
            hif16.halted, hif16.fwd1_sel, hif16.fwd2_sel};
  endfunction

  function automatic outs_t outs4();
    return {hif4.pc_hold, hif4.ifid_hold, hif4.ifid_flush, hif4.idex_bubble,
            hif4.halted, hif4.fwd1_sel, hif4.fwd2_sel};
  endfunction

  function automatic instr_t mk(bit wen, int unsigned wreg, bit ld, bit u1, int unsigned rs1, bit halt);
    instr_t c;
    c = '{v: 1'b1, rs1: rs1, rs2: 0, u1: u1, u2: 1'b0, wen: wen, wreg: wreg, ld: ld, halt: halt};
    return c;
  endfunction

  function automatic instr_t rand_instr();
    instr_t c;
    c.v    = ($urandom_range(0, 9) < 8);
    c.rs1  = $urandom_range(0, 7);
    c.rs2  = $urandom_range(0, 7);
    c.u1   = 1'($urandom_range(0, 1));
    c.u2   = 1'($urandom_range(0, 1));
    c.wen  = ($urandom_range(0, 3) != 0);
    c.wreg = $urandom_range(0, 7);
    c.ld   = ($urandom_range(0, 2) == 0);
    c.halt = ($urandom_range(0, 79) == 0);
    return c;
  endfunction

  task automatic drive(input instr_t c, input bit redir);
    hif16.id_valid    = c.v;
    hif16.id_rs1      = 3'(c.rs1);
    hif16.id_rs2      = 3'(c.rs2);
    hif16.id_use1     = c.u1;
    hif16.id_use2     = c.u2;
    hif16.id_wen      = c.wen;
    hif16.id_wreg     = 3'(c.wreg);
    hif16.id_memread  = c.ld;
    hif16.id_halt     = c.halt;
    hif16.ex_redirect = redir;
  endtask

  // Reference rules: age 0/1/2 = EX/MEM/WB of an in-flight register write.
  function automatic bit m_src_haz(bit use_src, int unsigned idx);
    if (!use_src) return 1'b0;
    foreach (fl[i]) begin
      if (fl[i].rg == idx) begin
`ifdef HAZARD_FWD_EN
        if (fl[i].age == 0 && fl[i].ld) return 1'b1;
`else
        return 1'b1;
`endif
      end
    end
    return 1'b0;
  endfunction

  function automatic logic [1:0] m_fwd(bit use_src, int unsigned idx);
`ifdef HAZARD_FWD_EN
    int unsigned best;
    best = 3;
    if (use_src)
      foreach (fl[i]) if (fl[i].rg == idx && fl[i].age < best) best = fl[i].age;
    return (best == 3) ? 2'd0 : 2'(best + 1);
`else
    return 2'd0;
`endif
  endfunction

  task automatic m_advance(input bit issue, input int unsigned rg, input bit ld);
    flight_t nf[$];
    foreach (fl[i]) if (fl[i].age < 2) nf.push_back('{rg: fl[i].rg, ld: fl[i].ld, age: fl[i].age + 1});
    if (issue) nf.push_back('{rg: rg, ld: ld, age: 0});
    fl = nf;
  endtask

  task automatic m_reset();
    fl.delete();
    m_halting     = 1'b0;
    m_halted      = 1'b0;
    m_stalls      = 0;
    halted_cycles = 0;
  endtask

  task automatic do_reset();
    instr_t idle;
    idle = '{default: 0};
    @(negedge clk);
    #3;
    rst = 1'b0;
    hif16.id_valid    = 1'b1;
    hif16.ex_redirect = 1'b1;
    hif16.id_use1     = 1'b1;
    hif16.id_wen      = 1'b1;
    #1;
    chk("async_rst_outs16", 32'(outs16()), 32'd0);
    chk("async_rst_outs4",  32'(outs4()),  32'd0);
    chk("async_rst_cnt16",  32'(hif16.stall_cnt), 32'd0);
    chk("async_rst_cnt4",   32'(hif4.stall_cnt),  32'd0);
    drive(idle, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    m_reset();
    first_ep = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("outs16", 32'(outs16()), 32'(e.o));
        chk("outs4",  32'(outs4()),  32'(e.o));
        chk("stall_cnt16", 32'(hif16.stall_cnt), (e.stalls > 65535) ? 32'd65535 : e.stalls);
        chk("stall_cnt4",  32'(hif4.stall_cnt),  (e.stalls > 15) ? 32'd15 : e.stalls);
      end
    end
  end

  initial begin : driver
    instr_t cur;
    outs_t  o;
    bit     hold, redir, haz, issue, drained;
    cur = '{default: 0};
    hold = 1'b0;
    first_ep = 1'b1;
    dirq.push_back(mk(1'b1, 3, 1'b0, 1'b0, 0, 1'b0));
    dirq.push_back(mk(1'b0, 0, 1'b0, 1'b1, 3, 1'b0));
    for (int k = 0; k < 18; k++) begin
      dirq.push_back(mk(1'b1, 2, 1'b1, 1'b0, 0, 1'b0));
      dirq.push_back(mk(1'b0, 0, 1'b0, 1'b1, 2, 1'b0));
    end
    dirq.push_back(mk(1'b1, 1, 1'b0, 1'b0, 0, 1'b0));
    dirq.push_back(mk(1'b1, 2, 1'b0, 1'b0, 0, 1'b0));
    dirq.push_back(mk(1'b0, 0, 1'b0, 1'b0, 0, 1'b1));
    drive(cur, 1'b0);
    m_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (!hold) cur = (dirq.size() != 0) ? dirq.pop_front() : rand_instr();
      redir = (m_halted || !first_ep) && ($urandom_range(0, m_halted ? 3 : 11) == 0);
      drive(cur, redir);

      o       = '0;
      issue   = 1'b0;
      haz     = cur.v && (m_src_haz(cur.u1, cur.rs1) || m_src_haz(cur.u2, cur.rs2));
      drained = 1'b1;
      foreach (fl[i]) if (fl[i].age < 2) drained = 1'b0;
      o.f1 = m_fwd(cur.u1, cur.rs1);
      o.f2 = m_fwd(cur.u2, cur.rs2);
      sbq.push_back('{o: o, stalls: m_stalls});
      if (m_halted) begin
        o.halted = 1'b1; o.pc_hold = 1'b1; o.ifid_hold = 1'b1;
        halted_cycles++;
      end else if (redir) begin
        o.ifid_flush = 1'b1; o.idex_bubble = 1'b1;
        m_halting = 1'b0;
      end else if (m_halting) begin
        o.pc_hold = 1'b1; o.idex_bubble = 1'b1;
        if (drained) begin m_halting = 1'b0; m_halted = 1'b1; end
      end else if (haz) begin
        o.pc_hold = 1'b1; o.ifid_hold = 1'b1; o.idex_bubble = 1'b1;
        m_stalls++;
      end else if (cur.v && cur.halt) begin
        o.pc_hold = 1'b1; o.idex_bubble = 1'b1;
        m_halting = 1'b1;
      end else begin
        issue = cur.v && cur.wen;
      end
      sbq[sbq.size() - 1].o = o;
      m_advance(issue, cur.wreg, cur.ld);
      hold = o.ifid_hold;

      if (halted_cycles >= 100) begin
        do_reset();
        hold = 1'b0;
      end
    end

    repeat (2) @(negedge clk);
    #4;
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
